// File: rtl/pipe_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_pattern_gen
//  Purpose  : Writer side of the pipe-scroller column interface. Follows the
//             scroller's 3-bit cycle phase and, on every boundary edge
//             (start=1, phase 7 -> 0), loads either an empty column or a
//             solid wall with a pseudo-random gap. The gap narrows as walls
//             are passed, and content freezes on crash or game over.
//
//  Ports    :
//    Clock     in   1  clock, rising edge active
//    reset     in   1  synchronous, active-high
//    start     in   1  run enable, shared with the scroller
//    crash     in   1  scroller crash flag (freezes column content)
//    gameOver  in   1  game over flag (freezes column content)
//    score     in   1  scroller score level, high while a wall is in column 4
//    pattern   out  8  column to load; bit i lit means row i is solid
//    slot      out  1  high while phase == 0, the cycle the scroller samples
//    gap       out  3  current gap height in rows
//    passed    out  8  walls passed, saturating at 255
//
//  Revision : 1.0  initial release
// ============================================================================
module pipe_pattern_gen #(
  parameter logic [7:0] SEED       = 8'hA5, // LFSR reset value, must be nonzero
  parameter int         SPACING    = 2,     // column slots per wall, 1..8
  parameter int         GAP_INIT   = 4,     // gap height after reset, 2..6
  parameter int         GAP_MIN    = 2,     // narrowest gap, 1..GAP_INIT
  parameter int         LEVEL_STEP = 4      // walls passed per gap decrement
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic       start,
  input  logic       crash,
  input  logic       gameOver,
  input  logic       score,
  output logic [7:0] pattern,
  output logic       slot,
  output logic [2:0] gap,
  output logic [7:0] passed
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [2:0]  SLOT_LAST = 3'(SPACING - 1);
  localparam logic [2:0]  GAP_RESET = 3'(GAP_INIT);
  localparam logic [2:0]  GAP_FLOOR = 3'(GAP_MIN);
  localparam int unsigned STEP      = LEVEL_STEP;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [2:0] phase;    // mirror of the scroller's cycle phase
  logic [7:0] lfsr;     // gap position source
  logic [2:0] slotcnt;  // slot index within the current wall period
  logic       score_d;  // previous score level for rise detection

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic       boundary;
  logic       frozen;
  logic       emit_wall;
  logic [3:0] max_start;
  logic [3:0] rnd;
  logic [3:0] gap_start;
  logic [3:0] gap_end;
  logic [7:0] wall;
  logic [7:0] lfsr_next;
  logic       rise;
  logic [7:0] passed_next;
  logic       level_up;

  assign slot      = (phase == 3'd0);
  assign boundary  = start && (phase == 3'd7);
  assign frozen    = crash || gameOver;
  assign emit_wall = (slotcnt == SLOT_LAST);

  // Gap placement. A raw 3-bit value above the last legal start row is
  // folded back to the bottom so every LFSR value maps to a valid position
  // without a divider.
  assign max_start = 4'd8 - {1'b0, gap};
  assign rnd       = {1'b0, lfsr[2:0]};
  assign gap_start = (rnd <= max_start) ? rnd : (rnd - max_start - 4'd1);
  assign gap_end   = gap_start + {1'b0, gap};

  // Row i of the wall is solid unless it falls inside [gap_start, gap_end).
  for (genvar i = 0; i < 8; i++) begin : g_row
    assign wall[i] = !((4'(i) >= gap_start) && (4'(i) < gap_end));
  end

  // Fibonacci LFSR, taps 8,6,5,4: maximal length, so zero is never reached
  // from a nonzero seed.
  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  // Score bookkeeping
  assign rise        = score && !score_d;
  assign passed_next = (passed == 8'hFF) ? passed : (passed + 8'd1);
  assign level_up    = rise
                    && (passed_next != 8'd0)
                    && ((32'(passed_next) % STEP) == 32'd0)
                    && (gap > GAP_FLOOR);

  // --------------------------------------------------------------------------
  // Phase counter: runs whenever start is high, even while frozen, so it
  // never drifts out of step with the scroller.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (reset) begin
      phase <= 3'd0;
    end else if (start) begin
      phase <= phase + 3'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Column generator. The new column is registered on the boundary edge so it
  // is already stable for the whole phase-0 cycle when the scroller loads it.
  // The wall reads the gap register before any same-edge decrement.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (reset) begin
      pattern <= 8'h00;
      lfsr    <= SEED;
      slotcnt <= 3'd0;
    end else if (boundary && !frozen) begin
      if (emit_wall) begin
        pattern <= wall;
        slotcnt <= 3'd0;
        lfsr    <= lfsr_next;
      end else begin
        pattern <= 8'h00;
        slotcnt <= slotcnt + 3'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Difficulty tracking. Independent of start and of the freeze flags: the
  // scroller itself stops producing rises when it is halted.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (reset) begin
      score_d <= 1'b0;
      passed  <= 8'd0;
      gap     <= GAP_RESET;
    end else begin
      score_d <= score;
      if (rise) begin
        passed <= passed_next;
      end
      if (level_up) begin
        gap <= gap - 3'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_pattern_gen
//  Purpose  : Directed self-checking bench for pipe_pattern_gen with
//             hand-computed expected columns, LFSR states and score counts.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_pattern_gen;

  logic       Clock = 1'b0;
  logic       reset;
  logic       start;
  logic       crash;
  logic       gameOver;
  logic       score;
  logic [7:0] pattern;
  logic       slot;
  logic [2:0] gap;
  logic [7:0] passed;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected column / LFSR for each 8-cycle block after reset, default
  // parameters, start held high, no crash.
  logic [7:0] exp_pat  [7] = '{8'h00, 8'h00, 8'hF0, 8'h00, 8'hC3, 8'h00, 8'hF0};
  logic [7:0] exp_lfsr [7] = '{8'hA5, 8'hA5, 8'h4A, 8'h4A, 8'h95, 8'h95, 8'h2A};

  always #5 Clock = ~Clock;

  pipe_pattern_gen dut (
    .Clock    (Clock),
    .reset    (reset),
    .start    (start),
    .crash    (crash),
    .gameOver (gameOver),
    .score    (score),
    .pattern  (pattern),
    .slot     (slot),
    .gap      (gap),
    .passed   (passed)
  );

  // One active edge, then settle before sampling or driving.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    start = 0; crash = 0; gameOver = 0; score = 0; reset = 1;
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    start = 0; crash = 0; gameOver = 0; score = 0; reset = 1;
    step(); step();
    reset = 0;
    n_cmp++; if (pattern !== 8'h00) begin n_bad++; $display("FAIL reset_pattern: got %h want 00", pattern); end
    n_cmp++; if (slot !== 1'b1) begin n_bad++; $display("FAIL reset_slot: got %b want 1", slot); end
    n_cmp++; if (gap !== 3'd4) begin n_bad++; $display("FAIL reset_gap: got %0d want 4", gap); end
    n_cmp++; if (passed !== 8'd0) begin n_bad++; $display("FAIL reset_passed: got %0d want 0", passed); end
    n_cmp++; if (dut.lfsr !== 8'hA5) begin n_bad++; $display("FAIL reset_lfsr: got %h want a5", dut.lfsr); end
    n_cmp++; if (dut.phase !== 3'd0) begin n_bad++; $display("FAIL reset_phase: got %0d want 0", dut.phase); end
    n_cmp++; if (dut.slotcnt !== 3'd0) begin n_bad++; $display("FAIL reset_slotcnt: got %0d want 0", dut.slotcnt); end
  endtask

  task automatic test_walls();
    logic es;
    do_reset();
    start = 1;
    for (int k = 1; k <= 48; k++) begin
      step();
      es = ((k % 8) == 0);
      n_cmp++; if (slot !== es) begin n_bad++; $display("FAIL walls_slot k=%0d: got %b want %b", k, slot, es); end
      n_cmp++; if (pattern !== exp_pat[k/8]) begin n_bad++; $display("FAIL walls_pattern k=%0d: got %h want %h", k, pattern, exp_pat[k/8]); end
      n_cmp++; if (dut.lfsr !== exp_lfsr[k/8]) begin n_bad++; $display("FAIL walls_lfsr k=%0d: got %h want %h", k, dut.lfsr, exp_lfsr[k/8]); end
      if (k == 8) begin
        n_cmp++; if (dut.slotcnt !== 3'd1) begin n_bad++; $display("FAIL walls_slotcnt: got %0d want 1", dut.slotcnt); end
      end
    end
  endtask

  // Continues from test_walls: phase 0, pattern F0, lfsr 2A, slotcnt 0.
  task automatic test_start_hold();
    step(); step(); step();
    start = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (dut.phase !== 3'd3) begin n_bad++; $display("FAIL hold_phase: got %0d want 3", dut.phase); end
      n_cmp++; if (slot !== 1'b0) begin n_bad++; $display("FAIL hold_slot: got %b want 0", slot); end
      n_cmp++; if (pattern !== 8'hF0) begin n_bad++; $display("FAIL hold_pattern: got %h want f0", pattern); end
    end
    start = 1;
    step(); step(); step(); step();
    // Parked at phase 7: no boundary may be taken without start.
    start = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (dut.phase !== 3'd7) begin n_bad++; $display("FAIL hold7_phase: got %0d want 7", dut.phase); end
      n_cmp++; if (pattern !== 8'hF0) begin n_bad++; $display("FAIL hold7_pattern: got %h want f0", pattern); end
      n_cmp++; if (dut.lfsr !== 8'h2A) begin n_bad++; $display("FAIL hold7_lfsr: got %h want 2a", dut.lfsr); end
    end
    start = 1;
    step();
    n_cmp++; if (slot !== 1'b1) begin n_bad++; $display("FAIL resume_slot: got %b want 1", slot); end
    n_cmp++; if (pattern !== 8'h00) begin n_bad++; $display("FAIL resume_pattern: got %h want 00", pattern); end
  endtask

  task automatic test_crash();
    logic [7:0] ep, el;
    do_reset();
    start = 1;
    for (int k = 1; k <= 56; k++) begin
      crash    = (k > 20 && k <= 30);
      gameOver = (k > 30 && k <= 44);
      step();
      ep = (k < 16) ? 8'h00 : (k < 48) ? 8'hF0 : (k < 56) ? 8'h00 : 8'hC3;
      el = (k < 16) ? 8'hA5 : (k < 56) ? 8'h4A : 8'h95;
      n_cmp++; if (pattern !== ep) begin n_bad++; $display("FAIL crash_pattern k=%0d: got %h want %h", k, pattern, ep); end
      n_cmp++; if (dut.lfsr !== el) begin n_bad++; $display("FAIL crash_lfsr k=%0d: got %h want %h", k, dut.lfsr, el); end
      n_cmp++; if (dut.phase !== 3'(k % 8)) begin n_bad++; $display("FAIL crash_phase k=%0d: got %0d want %0d", k, dut.phase, k % 8); end
      if (k == 47) begin
        n_cmp++; if (dut.slotcnt !== 3'd0) begin n_bad++; $display("FAIL crash_slotcnt47: got %0d want 0", dut.slotcnt); end
      end
      if (k == 48) begin
        n_cmp++; if (dut.slotcnt !== 3'd1) begin n_bad++; $display("FAIL crash_slotcnt48: got %0d want 1", dut.slotcnt); end
      end
    end
    crash = 0; gameOver = 0;
  endtask

  task automatic test_score();
    logic [2:0] eg;
    do_reset();
    start = 0;
    for (int p = 1; p <= 12; p++) begin
      score = 1; step(); step();
      score = 0; step(); step();
      eg = (p < 4) ? 3'd4 : (p < 8) ? 3'd3 : 3'd2;
      n_cmp++; if (passed !== 8'(p)) begin n_bad++; $display("FAIL score_passed p=%0d: got %0d want %0d", p, passed, p); end
      n_cmp++; if (gap !== eg) begin n_bad++; $display("FAIL score_gap p=%0d: got %0d want %0d", p, gap, eg); end
    end
    for (int p = 13; p <= 312; p++) begin
      score = 1; step(); step();
      score = 0; step(); step();
      if (p == 254 || p == 255) begin
        n_cmp++; if (passed !== 8'(p)) begin n_bad++; $display("FAIL score_near_sat p=%0d: got %0d want %0d", p, passed, p); end
      end
    end
    n_cmp++; if (passed !== 8'hFF) begin n_bad++; $display("FAIL score_saturate: got %h want ff", passed); end
    n_cmp++; if (gap !== 3'd2) begin n_bad++; $display("FAIL score_gap_floor: got %0d want 2", gap); end
  endtask

  task automatic test_coincident();
    do_reset();
    start = 1;
    for (int k = 1; k <= 17; k++) begin
      score = (k == 1 || k == 2 || k == 5 || k == 6 || k == 9 || k == 10 || k == 16 || k == 17);
      step();
      if (k == 15) begin
        n_cmp++; if (passed !== 8'd3) begin n_bad++; $display("FAIL coin_passed_pre: got %0d want 3", passed); end
        n_cmp++; if (gap !== 3'd4) begin n_bad++; $display("FAIL coin_gap_pre: got %0d want 4", gap); end
      end
      if (k == 16) begin
        n_cmp++; if (pattern !== 8'hF0) begin n_bad++; $display("FAIL coin_pattern: got %h want f0", pattern); end
        n_cmp++; if (gap !== 3'd3) begin n_bad++; $display("FAIL coin_gap_post: got %0d want 3", gap); end
        n_cmp++; if (passed !== 8'd4) begin n_bad++; $display("FAIL coin_passed_post: got %0d want 4", passed); end
      end
    end
    score = 0;
  endtask

  task automatic test_mid_reset();
    logic es;
    do_reset();
    start = 1;
    for (int k = 1; k <= 37; k++) begin
      score = (k <= 36) && (((k - 1) % 4) < 2);
      step();
    end
    score = 0;
    n_cmp++; if (dut.phase !== 3'd5) begin n_bad++; $display("FAIL mid_pre_phase: got %0d want 5", dut.phase); end
    n_cmp++; if (passed !== 8'd9) begin n_bad++; $display("FAIL mid_pre_passed: got %0d want 9", passed); end
    n_cmp++; if (gap !== 3'd2) begin n_bad++; $display("FAIL mid_pre_gap: got %0d want 2", gap); end
    reset = 1;
    step();
    reset = 0;
    n_cmp++; if (dut.phase !== 3'd0) begin n_bad++; $display("FAIL mid_phase: got %0d want 0", dut.phase); end
    n_cmp++; if (pattern !== 8'h00) begin n_bad++; $display("FAIL mid_pattern: got %h want 00", pattern); end
    n_cmp++; if (gap !== 3'd4) begin n_bad++; $display("FAIL mid_gap: got %0d want 4", gap); end
    n_cmp++; if (passed !== 8'd0) begin n_bad++; $display("FAIL mid_passed: got %0d want 0", passed); end
    n_cmp++; if (dut.lfsr !== 8'hA5) begin n_bad++; $display("FAIL mid_lfsr: got %h want a5", dut.lfsr); end
    for (int k = 1; k <= 48; k++) begin
      step();
      es = ((k % 8) == 0);
      n_cmp++; if (slot !== es) begin n_bad++; $display("FAIL replay_slot k=%0d: got %b want %b", k, slot, es); end
      n_cmp++; if (pattern !== exp_pat[k/8]) begin n_bad++; $display("FAIL replay_pattern k=%0d: got %h want %h", k, pattern, exp_pat[k/8]); end
      n_cmp++; if (dut.lfsr !== exp_lfsr[k/8]) begin n_bad++; $display("FAIL replay_lfsr k=%0d: got %h want %h", k, dut.lfsr, exp_lfsr[k/8]); end
    end
  endtask

  initial begin
    reset = 1; start = 0; crash = 0; gameOver = 0; score = 0;
    test_reset();
    test_walls();
    test_start_hold();
    test_crash();
    test_score();
    test_coincident();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
